// File: rtl/mem_if_pkg.sv
// Shared widths, FSM state encoding and command codes for the memory-port arbiter.
package mem_if_pkg;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
endpackage

// File: rtl/arb_prio_pick.sv
// Fixed-priority winner select for two requesters with a starvation guard:
// after MAX_SKIP contended losses the low-priority requester is forced to win.
module arb_prio_pick #(
  parameter int PRIO_PORT = 1,
  parameter int MAX_SKIP  = 4,
  localparam int SKIP_W   = $clog2(MAX_SKIP + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic              grant_en,
  output logic              winner,
  output logic [SKIP_W-1:0] skip_cnt
);

  localparam logic HI = 1'(PRIO_PORT);
  localparam logic LO = ~HI;

  logic starved;

  assign starved = (skip_cnt == SKIP_W'(MAX_SKIP));

  always_comb begin
    winner = HI;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = starved ? LO : HI;
      default: winner = HI;
    endcase
  end

  // Only a contended loss counts as a skip; any grant to the low-priority side clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (grant_en && (req != 2'b00)) begin
      if (winner == LO)
        skip_cnt <= '0;
      else if ((req == 2'b11) && !starved)
        skip_cnt <= skip_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-client (Icache=0, Dcache=1) arbiter in front of the DDR2 controller port:
// one line request in flight, one-cycle ready pulse back, sticky MC timeout flag.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int PRIO_PORT = 1,
  parameter int MAX_SKIP  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [LINE_W-1:0] c0_data_wr,
  input  logic              c0_rw,
  input  logic              c0_valid,
  output logic              c0_ready,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LINE_W-1:0] c1_data_wr,
  input  logic              c1_rw,
  input  logic              c1_valid,
  output logic              c1_ready,
  output logic [LINE_W-1:0] c_data_rd,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [LINE_W-1:0] mc_data_wr,
  output logic              mc_rw,
  output logic              mc_valid,
  input  logic              mc_ready,
  input  logic [LINE_W-1:0] mc_data_rd,
  output logic              error
);

  localparam int SKIP_W = $clog2(MAX_SKIP + 1);

  state_t            state;
  state_t            state_nxt;
  logic              grant_en;
  logic              win;
  logic              gnt;
  logic [7:0]        tmo_cnt;
  logic [SKIP_W-1:0] skip_cnt;

  arb_prio_pick #(
    .PRIO_PORT (PRIO_PORT),
    .MAX_SKIP  (MAX_SKIP)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({c1_valid, c0_valid}),
    .grant_en (grant_en),
    .winner   (win),
    .skip_cnt (skip_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (c0_valid || c1_valid) begin
          grant_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (mc_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mc_addr    <= '0;
      mc_data_wr <= '0;
      mc_rw      <= CMD_RD;
      mc_valid   <= 1'b0;
      c_data_rd  <= '0;
      c0_ready   <= 1'b0;
      c1_ready   <= 1'b0;
      gnt        <= 1'b0;
      tmo_cnt    <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            mc_addr    <= win ? c1_addr    : c0_addr;
            mc_data_wr <= win ? c1_data_wr : c0_data_wr;
            mc_rw      <= win ? c1_rw      : c0_rw;
            mc_valid   <= 1'b1;
            gnt        <= win;
            tmo_cnt    <= '0;
          end
        end
        ISSUE: begin
          // Counter saturates; error only flags, the MC is still waited on.
          if (tmo_cnt != '1)
            tmo_cnt <= tmo_cnt + 8'd1;
          if (tmo_cnt >= 8'(TIMEOUT - 1))
            error <= 1'b1;
          if (mc_ready) begin
            mc_valid  <= 1'b0;
            c_data_rd <= mc_data_rd;
            c0_ready  <= ~gnt;
            c1_ready  <= gnt;
          end
        end
        RESP: begin
          c0_ready <= 1'b0;
          c1_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  a_skip_bound: assert property (@(posedge clk) disable iff (!rst_n)
    skip_cnt <= SKIP_W'(MAX_SKIP));

endmodule
